cipher_sched: RTL and testbench
===============================

CIPHER_SCHED -- requirements
Module: cipher_sched

Interface
REQ-001 Parameter N, default 8, data width of cipher byte.
REQ-002 Parameter TIMEOUT, default 16, max cycles waited for core_v after issue.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  2  per-channel request valid (channel 0, 1).
REQ-006 req_ready  out  2  per-channel request accept; one-hot or zero.
REQ-007 req_din  in  2xN  per-channel plaintext/ciphertext byte.
REQ-008 req_shift  in  2x5  per-channel shift amount 0..31.
REQ-009 req_dir  in  2x2  per-channel direction code.
REQ-010 core_en  out  1  issue strobe to shift-cipher core.
REQ-011 core_din  out  N  byte to core.
REQ-012 core_shift_num  out  5  normalized shift to core.
REQ-013 core_direction  out  2  direction to core.
REQ-014 core_dout  in  N  core result.
REQ-015 core_v  in  1  core result valid.
REQ-016 resp_valid  out  1  response valid.
REQ-017 resp_ready  in  1  response accept.
REQ-018 resp_ch  out  1  channel owning response.
REQ-019 resp_data  out  N  result byte.
REQ-020 resp_err  out  1  timeout or illegal-direction flag.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one core transaction in flight.
REQ-022 In IDLE, req_ready[g] SHALL be 1 combinationally for granted channel g when any req_valid is 1; handshake = valid&&ready.
REQ-023 Arbitration SHALL be round-robin: both valid -> grant channel not granted last; last_grant updates on response handshake.
REQ-024 On request handshake, din, normalized shift and dir SHALL be registered; next state ISSUE, or RESP with resp_err=1, resp_data=0 when dir==2'b11 (core untouched).
REQ-025 Normalized shift SHALL be req_shift mod 26 (26..31 -> 0..5); 5-bit result.
REQ-026 ISSUE SHALL last one cycle with core_en=1 and core_din/core_shift_num/core_direction driven from registers; next WAIT.
REQ-027 core_din/core_shift_num/core_direction SHALL hold registered values from ISSUE until return to IDLE; core_en=0 outside ISSUE.
REQ-028 In WAIT, core_v=1 SHALL capture core_dout into resp_data, resp_err=0, next RESP.
REQ-029 WAIT timer SHALL start at 0 on entry; core_v absent for TIMEOUT cycles -> RESP with resp_err=1, resp_data=0.
REQ-030 core_v on the same cycle as timeout expiry SHALL win (no error).
REQ-031 core_v outside WAIT SHALL be ignored.
REQ-032 In RESP, resp_valid=1 with resp_ch/resp_data/resp_err stable until resp_ready=1; then IDLE next cycle.
REQ-033 Minimum turnaround request-handshake to resp_valid SHALL be 3 cycles (core_v in first WAIT cycle).
REQ-034 req_ready SHALL be 0 in ISSUE, WAIT, RESP; requesters hold payload until handshake.

Reset
REQ-035 rst=0 at a clock edge SHALL force IDLE, last_grant=1 (channel 0 wins first tie), timer=0, all outputs 0.
REQ-036 Reset mid-transaction SHALL discard the in-flight request and any late core_v without response.

Structure
REQ-037 Package cipher_sched_pkg SHALL hold state enum, NCH=2, SHIFT_MOD=26, direction codes, default TIMEOUT.
REQ-038 Arbiter SHALL be sub-module rr_arb2 (req[1:0], last, grant one-hot).

Verification (bench core model: core_v 2 cycles after core_en, dout = din+shift)
REQ-039 ch0 only, din=8'h0B, shift=5, dir=00 -> core_shift_num=5, resp_ch=0, resp_data=8'h10, resp_err=0.
REQ-040 both valid from reset -> ch0 granted first, ch1 second; repeated ties alternate 0,1,0,1.
REQ-041 shift=26 then 31 -> core_shift_num=0 then 5.
REQ-042 core model silenced -> resp_err=1, resp_data=0, resp_valid exactly TIMEOUT+2 cycles after handshake; dir=11 -> core_en never asserted, resp_err=1.
REQ-043 resp_ready held 0 for 5 cycles -> response fields stable, req_ready stays 0; rst=0 during WAIT -> no response, next request serviced normally.

Source files
------------

// File: rtl/cipher_sched_pkg.sv
// cipher_sched_pkg: shared types and constants for the cipher request scheduler.
//   state_e     - scheduler FSM states
//   NCH         - number of requesting channels
//   SHIFT_MOD   - modulus applied to requested shift amounts
//   DIR_*       - direction codes; DIR_ILLEGAL is rejected without touching the core
//   norm_shift  - folds a 5-bit shift into 0..SHIFT_MOD-1
package cipher_sched_pkg;

    localparam int unsigned NCH             = 2;
    localparam int unsigned SHIFT_MOD       = 26;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    localparam logic [1:0] DIR_0       = 2'b00;
    localparam logic [1:0] DIR_1       = 2'b01;
    localparam logic [1:0] DIR_2       = 2'b10;
    localparam logic [1:0] DIR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // A 5-bit input is at most 31, so one conditional subtract is a full mod 26.
    function automatic logic [4:0] norm_shift(input logic [4:0] s);
        return (s >= 5'(SHIFT_MOD)) ? (s - 5'(SHIFT_MOD)) : s;
    endfunction

endpackage

// File: rtl/cipher_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   req   - request bits, one per channel
//   last  - channel granted most recently
//   grant - one-hot grant, or zero when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = req;
        endcase
    end

endmodule

// File: rtl/cipher_sched.sv
// cipher_sched: arbitrates two request channels onto a single shift-cipher core,
// one transaction in flight at a time, with a response timeout.
//   clock, rst                     - clock, synchronous active-low reset
//   req_valid/req_ready            - per-channel request handshake
//   req_din/req_shift/req_dir      - per-channel payload
//   core_en/core_din/core_shift_num/core_direction - issue interface to the core
//   core_dout/core_v               - core result
//   resp_valid/resp_ready          - response handshake
//   resp_ch/resp_data/resp_err     - response payload
module cipher_sched
    import cipher_sched_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH-1:0][N-1:0]    req_din,
    input  logic [NCH-1:0][4:0]      req_shift,
    input  logic [NCH-1:0][1:0]      req_dir,
    output logic                     core_en,
    output logic [N-1:0]             core_din,
    output logic [4:0]               core_shift_num,
    output logic [1:0]               core_direction,
    input  logic [N-1:0]             core_dout,
    input  logic                     core_v,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_ch,
    output logic [N-1:0]             resp_data,
    output logic                     resp_err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic           ch_q, ch_d;
    logic [N-1:0]   din_q, din_d;
    logic [4:0]     shift_q, shift_d;
    logic [1:0]     dir_q, dir_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [N-1:0]   data_q, data_d;
    logic           err_q, err_d;

    logic [1:0]     grant;
    logic           gch;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign gch = grant[1];

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            ch_q    <= 1'b0;
            din_q   <= '0;
            shift_q <= '0;
            dir_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            din_q   <= din_d;
            shift_q <= shift_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        din_d   = din_q;
        shift_d = shift_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                // Ready mirrors the grant, so any nonzero grant is a handshake.
                if (|grant) begin
                    ch_d    = gch;
                    din_d   = req_din[gch];
                    shift_d = norm_shift(req_shift[gch]);
                    dir_d   = req_dir[gch];
                    if (req_dir[gch] == DIR_ILLEGAL) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + TW'(1);
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (core_v) begin
                    data_d  = core_dout;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    last_d  = ch_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready      = (state_q == StIdle) ? grant : '0;
    assign core_en        = (state_q == StIssue);
    assign core_din       = (state_q != StIdle) ? din_q : '0;
    assign core_shift_num = (state_q != StIdle) ? shift_q : '0;
    assign core_direction = (state_q != StIdle) ? dir_q : '0;
    assign resp_valid     = (state_q == StResp);
    assign resp_ch        = ch_q;
    assign resp_data      = data_q;
    assign resp_err       = err_q;

endmodule

// File: tb/tb_cipher_sched.sv
module tb_cipher_sched;

    localparam int N       = 8;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][7:0]  req_din;
    logic [1:0][4:0]  req_shift;
    logic [1:0][1:0]  req_dir;
    logic             core_en;
    logic [7:0]       core_din;
    logic [4:0]       core_shift_num;
    logic [1:0]       core_direction;
    logic [7:0]       core_dout;
    logic             core_v;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_ch;
    logic [7:0]       resp_data;
    logic             resp_err;

    int checks = 0;
    int errors = 0;

    // Core model: result valid two cycles after core_en (one when core_lat==1), dout=din+shift.
    logic       model_on = 1'b1;
    int         core_lat = 2;
    logic [1:0] pipe = 2'b00;
    logic [7:0] model_dout = 8'h00;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        pipe <= {pipe[0], core_en};
        if (core_en) model_dout <= core_din + 8'(core_shift_num);
    end

    assign core_v    = model_on && ((core_lat == 1) ? pipe[0] : pipe[1]);
    assign core_dout = model_dout;

    cipher_sched #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_din        (req_din),
        .req_shift      (req_shift),
        .req_dir        (req_dir),
        .core_en        (core_en),
        .core_din       (core_din),
        .core_shift_num (core_shift_num),
        .core_direction (core_direction),
        .core_dout      (core_dout),
        .core_v         (core_v),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_ch        (resp_ch),
        .resp_data      (resp_data),
        .resp_err       (resp_err)
    );

    task automatic do_reset();
        @(negedge clock);
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b1;
    endtask

    // Drives one request, counts cycles from the handshake cycle (0) to resp_valid,
    // optionally stalls resp_ready for 'hold' cycles, then accepts the response.
    task automatic run_req(input int ch, input logic [7:0] din, input logic [4:0] sh,
                           input logic [1:0] dir, input int hold,
                           output logic [4:0] got_shift, output int en_cnt, output int lat,
                           output logic got_ch, output logic [7:0] got_data,
                           output logic got_err, output logic stable_ok);
        int t;
        got_shift = '0;
        en_cnt    = 0;
        lat       = -1;
        got_ch    = 1'b0;
        got_data  = '0;
        got_err   = 1'b0;
        stable_ok = 1'b1;
        @(negedge clock);
        req_valid      = '0;
        req_valid[ch]  = 1'b1;
        req_din[ch]    = din;
        req_shift[ch]  = sh;
        req_dir[ch]    = dir;
        #1;
        t = 0;
        while (!req_ready[ch] && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (t == 50) begin
            req_valid = '0;
            return;
        end
        @(negedge clock);
        req_valid = '0;
        for (int k = 1; k < 100; k++) begin
            if (core_en) begin
                en_cnt++;
                got_shift = core_shift_num;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
        if (lat < 0) return;
        got_ch   = resp_ch;
        got_data = resp_data;
        got_err  = resp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'b11;
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_ch !== got_ch || resp_data !== got_data ||
                resp_err !== got_err || req_ready !== 2'b00)
                stable_ok = 1'b0;
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({req_ready, core_en, core_din, core_shift_num, core_direction,
             resp_valid, resp_ch, resp_data, resp_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req_ready=%b core_en=%b core_din=%h shift=%0d dir=%b resp_valid=%b resp_data=%h resp_err=%b, want all 0",
                     req_ready, core_en, core_din, core_shift_num, core_direction,
                     resp_valid, resp_data, resp_err);
        end
    endtask

    task automatic test_basic();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        run_req(0, 8'h0B, 5'd5, 2'b00, 0, s, en, lat, c, d, e, ok);
        checks++;
        if (s !== 5'd5 || en !== 1) begin
            errors++;
            $display("FAIL basic_issue: got shift=%0d en_cnt=%0d, want shift=5 en_cnt=1", s, en);
        end
        checks++;
        if (c !== 1'b0 || d !== 8'h10 || e !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL basic_resp: got ch=%b data=%h err=%b lat=%0d, want ch=0 data=10 err=0 lat=4",
                     c, d, e, lat);
        end
    endtask

    task automatic test_tie();
        logic [1:0] g, exp;
        int k;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clock);
            req_valid = 2'b11;
            req_din   = {8'(i), 8'(i)};
            req_shift = '0;
            req_dir   = '0;
            #1;
            g = req_ready;
            checks++;
            if (g !== exp) begin
                errors++;
                $display("FAIL tie_grant%0d: got req_ready=%b, want %b", i, g, exp);
            end
            @(negedge clock);
            req_valid = '0;
            k = 0;
            while (!resp_valid && k < 50) begin
                @(negedge clock);
                k++;
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_ch !== exp[1]) begin
                errors++;
                $display("FAIL tie_resp_ch%0d: got resp_valid=%b resp_ch=%b, want 1 and %b",
                         i, resp_valid, resp_ch, exp[1]);
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_shift_wrap();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        run_req(1, 8'h20, 5'd26, 2'b01, 0, s, en, lat, c, d, e, ok);
        checks++;
        if (s !== 5'd0 || c !== 1'b1 || d !== 8'h20 || e !== 1'b0) begin
            errors++;
            $display("FAIL shift26: got shift=%0d ch=%b data=%h err=%b, want 0 1 20 0", s, c, d, e);
        end
        run_req(1, 8'hFE, 5'd31, 2'b10, 0, s, en, lat, c, d, e, ok);
        checks++;
        if (s !== 5'd5 || d !== 8'h03 || e !== 1'b0) begin
            errors++;
            $display("FAIL shift31: got shift=%0d data=%h err=%b, want 5 03 0", s, d, e);
        end
    endtask

    task automatic test_min_latency();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        core_lat = 1;
        run_req(0, 8'h61, 5'd1, 2'b00, 0, s, en, lat, c, d, e, ok);
        core_lat = 2;
        checks++;
        if (lat !== 3 || d !== 8'h62 || e !== 1'b0) begin
            errors++;
            $display("FAIL min_latency: got lat=%0d data=%h err=%b, want 3 62 0", lat, d, e);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        model_on = 1'b0;
        run_req(0, 8'h55, 5'd3, 2'b01, 0, s, en, lat, c, d, e, ok);
        model_on = 1'b1;
        checks++;
        if (e !== 1'b1 || d !== 8'h00 || lat !== TIMEOUT + 2 || en !== 1) begin
            errors++;
            $display("FAIL timeout: got err=%b data=%h lat=%0d en_cnt=%0d, want 1 00 %0d 1",
                     e, d, lat, en, TIMEOUT + 2);
        end
    endtask

    task automatic test_illegal_dir();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        run_req(1, 8'h77, 5'd4, 2'b11, 0, s, en, lat, c, d, e, ok);
        checks++;
        if (en !== 0 || e !== 1'b1 || d !== 8'h00 || c !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_dir: got en_cnt=%0d err=%b data=%h ch=%b lat=%0d, want 0 1 00 1 1",
                     en, e, d, c, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        run_req(0, 8'h40, 5'd2, 2'b10, 5, s, en, lat, c, d, e, ok);
        checks++;
        if (ok !== 1'b1 || d !== 8'h42 || e !== 1'b0) begin
            errors++;
            $display("FAIL backpressure: got stable=%b data=%h err=%b, want 1 42 0", ok, d, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] s; int en, lat; logic c, e, ok; logic [7:0] d;
        logic seen;
        @(negedge clock);
        req_valid    = 2'b10;
        req_din[1]   = 8'h99;
        req_shift[1] = 5'd1;
        req_dir[1]   = 2'b00;
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid || core_en) seen = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got activity=%b after reset, want 0", seen);
        end
        run_req(0, 8'h33, 5'd30, 2'b00, 0, s, en, lat, c, d, e, ok);
        checks++;
        if (s !== 5'd4 || d !== 8'h37 || e !== 1'b0 || c !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL reset_mid_next: got shift=%0d data=%h err=%b ch=%b lat=%0d, want 4 37 0 0 4",
                     s, d, e, c, lat);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_din    = '0;
        req_shift  = '0;
        req_dir    = '0;
        resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_shift_wrap();
        test_min_latency();
        test_timeout();
        test_illegal_dir();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
